// File: rtl/cdc_hs_rx.sv
// Destination side of a toggle req/ack CDC handshake: captures a held data bus on a
// request toggle, offers it on valid/ready, and returns an ack toggle. Optional error
// tracking is enabled by defining CDC_HS_RX_ERR_EN.
module cdc_hs_rx #(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_sync,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 ack_tgl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 dbg_state
);

    // Handshake: a word transfers on any edge where out_valid && out_ready are both high;
    // out_valid stays high and out_data stays constant until that edge.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                req_q;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                req_evt;

    assign req_evt = req_sync ^ req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_sync;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_evt) begin
                    data_d  = data_in;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // A request event here is a source violation and is simply ignored.
                if (out_ready) begin
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack_tgl   = ack_q;
    assign out_valid = (state_q == ST_VALID);
    assign out_data  = data_q;
    assign dbg_state = (state_q == ST_VALID);

`ifdef CDC_HS_RX_ERR_EN
    logic                 viol;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    assign viol = req_evt && (state_q == ST_VALID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (viol) begin
            err_d = 1'b1;
            if (cnt_q != {ERR_CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = cnt_q;
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: scoreboard of expected words plus directed checks
// on reset, latency, backpressure, violations and async reset.
module tb_cdc_hs_rx;

    localparam int DATA_W    = 8;
    localparam int ERR_CNT_W = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 req_sync;
    logic [DATA_W-1:0]    data_in;
    logic                 ack_tgl;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

`ifdef CDC_HS_RX_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    cdc_hs_rx #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_sync  (req_sync),
        .data_in   (data_in),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // scoreboard: every accepted word must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(out_data), 32'hDEAD);
            end else begin
                check("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_req(input logic [DATA_W-1:0] d, input bit expect_word);
        data_in  = d;
        req_sync = ~req_sync;
        if (expect_word) exp_q.push_back(d);
    endtask

    task automatic wait_ack(input logic exp_ack);
        int n = 0;
        while (ack_tgl !== exp_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", 32'(ack_tgl), 32'(exp_ack));
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        rst_n     = 1'b0;
        req_sync  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ack",   32'(ack_tgl),   32'h0);
        check("rst_data",  32'(out_data),  32'h0);
        check("rst_err",   32'(err),       32'h0);
        check("rst_cnt",   32'(err_cnt),   32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        rst_n = 1'b1;

        // single word, ready high
        tick();
        out_ready = 1'b1;
        toggle_req(8'hA5, 1'b1);
        @(negedge clk);
        check("t1_pre_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data",  32'(out_data),  32'hA5);
        check("t1_ack0",  32'(ack_tgl),   32'h0);
        @(negedge clk);
        check("t1_valid_drop", 32'(out_valid), 32'h0);
        check("t1_ack1",       32'(ack_tgl),   32'h1);

        // backpressure
        tick();
        out_ready = 1'b0;
        toggle_req(8'h3C, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_data",  32'(out_data),  32'h3C);
            check("bp_ack",   32'(ack_tgl),   32'h1);
        end
        tick();
        out_ready = 1'b1;
        wait_ack(1'b0);
        check("bp_valid_drop", 32'(out_valid), 32'h0);

        // stream of four words, each after the previous ack
        for (int i = 1; i <= 4; i++) begin
            tick();
            d = DATA_W'(i);
            toggle_req(d, 1'b1);
            wait_ack(~ack_tgl);
        end
        check("stream_ack_final", 32'(ack_tgl), 32'h0);
        check("stream_drained",   32'(exp_q.size()), 32'h0);

        // violation: re-toggle while VALID with changed data
        tick();
        out_ready = 1'b0;
        toggle_req(8'h5A, 1'b1);
        tick();
        toggle_req(8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        check("viol_data",  32'(out_data),  32'h5A);
        check("viol_valid", 32'(out_valid), 32'h1);
        check("viol_ack",   32'(ack_tgl),   32'h0);
        check("viol_err",   32'(err),       32'(ERR_ON));
        check("viol_cnt",   32'(err_cnt),   ERR_ON ? 32'h1 : 32'h0);
        tick();
        out_ready = 1'b1;
        wait_ack(1'b1);
        repeat (4) begin
            @(negedge clk);
            check("viol_no_second_word", 32'(out_valid), 32'h0);
        end
        check("viol_single_ack", 32'(ack_tgl), 32'h1);

        // saturation: 20 more violations
        tick();
        out_ready = 1'b0;
        toggle_req(8'h77, 1'b1);
        tick();
        for (int i = 0; i < 20; i++) begin
            toggle_req(DATA_W'($urandom_range(0, 255)), 1'b0);
            tick();
        end
        @(negedge clk);
        check("sat_cnt",  32'(err_cnt),  ERR_ON ? 32'hF : 32'h0);
        check("sat_err",  32'(err),      32'(ERR_ON));
        check("sat_data", 32'(out_data), 32'h77);
        tick();
        out_ready = 1'b1;
        wait_ack(1'b0);

        // async reset while VALID
        tick();
        out_ready = 1'b0;
        toggle_req(8'h9C, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("ar_pre_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_ack",   32'(ack_tgl),   32'h0);
        check("ar_data",  32'(out_data),  32'h0);
        check("ar_err",   32'(err),       32'h0);
        check("ar_cnt",   32'(err_cnt),   32'h0);
        exp_q.delete();
        req_sync = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        data_in   = 8'hC3;
        req_sync  = 1'b1;
        exp_q.push_back(8'hC3);
        wait_ack(1'b1);
        check("ar_drained", 32'(exp_q.size()), 32'h0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
